// File: rtl/pwm_multi_channel_pkg.sv
// Shared types and default widths for the multi-channel PWM generator.
package pwm_multi_channel_pkg;

  localparam int unsigned DEF_N_CH    = 4;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_PRESC_W = 8;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Control/pin bundle between the register block and the PWM generator.
interface pwm_multi_channel_if #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PRESC_W = 8
);

  logic                    en;
  logic                    center_mode;
  logic [PRESC_W-1:0]      prescale;
  logic [CNT_W-1:0]        period;
  logic [N_CH*CNT_W-1:0]   duty;
  logic [N_CH-1:0]         polarity;
  logic [N_CH-1:0]         pwm;
  logic                    period_tick;

  // Control side: drives configuration, observes pins.
  modport master (
    output en, center_mode, prescale, period, duty, polarity,
    input  pwm, period_tick
  );

  // Generator side.
  modport slave (
    input  en, center_mode, prescale, period, duty, polarity,
    output pwm, period_tick
  );

endinterface

// File: rtl/pwm_multi_channel_timebase.sv
// Shared timebase: prescaler, up/down period counter and shadow-load strobe.
module pwm_multi_channel_timebase
  import pwm_multi_channel_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale_sh,
  input  logic [CNT_W-1:0]   period_sh,
  input  pwm_mode_e          mode_sh,
  output logic [CNT_W-1:0]   cnt,
  output logic               run,
  output logic               load_c
);

  logic [PRESC_W-1:0] presc;
  pwm_dir_e           dir;
  logic               tick_c;
  logic               wrap_c;

  assign tick_c = (presc == prescale_sh);

  // Last count of the current period: the next tick starts a new one.
  always_comb begin
    wrap_c = 1'b0;
    if (period_sh == '0) begin
      wrap_c = 1'b1;
    end else if (mode_sh == PWM_EDGE) begin
      wrap_c = (cnt == period_sh);
    end else if (dir == DIR_DOWN) begin
      wrap_c = (cnt == CNT_W'(1));
    end else begin
      // period of one in center mode never turns down: sequence 0,1,0
      wrap_c = (cnt == period_sh) && (period_sh == CNT_W'(1));
    end
  end

  // First enabled clock is always a boundary so the shadows start from the inputs.
  assign load_c = en && (!run || (tick_c && wrap_c));

  // Prescaler, counter and direction state.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
      dir   <= DIR_UP;
      run   <= 1'b0;
    end else if (!en) begin
      presc <= '0;
      cnt   <= '0;
      dir   <= DIR_UP;
      run   <= 1'b0;
    end else if (load_c) begin
      presc <= '0;
      cnt   <= '0;
      dir   <= DIR_UP;
      run   <= 1'b1;
    end else if (tick_c) begin
      presc <= '0;
      if (mode_sh == PWM_EDGE) begin
        cnt <= cnt + CNT_W'(1);
      end else if (dir == DIR_UP) begin
        if (cnt == period_sh) begin
          dir <= DIR_DOWN;
          cnt <= cnt - CNT_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared timebase, shadowed configuration, per-channel compare.
module pwm_multi_channel
  import pwm_multi_channel_pkg::*;
#(
  parameter int unsigned N_CH    = DEF_N_CH,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  pwm_multi_channel_if.slave bus
);

  logic [PRESC_W-1:0]    prescale_sh;
  logic [CNT_W-1:0]      period_sh;
  logic [N_CH*CNT_W-1:0] duty_sh;
  logic [N_CH-1:0]       pol_sh;
  pwm_mode_e             mode_sh;

  logic [CNT_W-1:0]      cnt;
  logic                  run;
  logic                  load_c;
  logic [N_CH-1:0]       raw_c;
  logic [N_CH-1:0]       pwm_q;
  logic                  period_tick_q;

  pwm_multi_channel_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .en          (bus.en),
    .prescale_sh (prescale_sh),
    .period_sh   (period_sh),
    .mode_sh     (mode_sh),
    .cnt         (cnt),
    .run         (run),
    .load_c      (load_c)
  );

  // Shadow registers: only move at a period boundary so a period is never altered mid-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_sh <= '0;
      period_sh   <= '0;
      duty_sh     <= '0;
      pol_sh      <= '0;
      mode_sh     <= PWM_EDGE;
    end else if (load_c) begin
      prescale_sh <= bus.prescale;
      period_sh   <= bus.period;
      duty_sh     <= bus.duty;
      pol_sh      <= bus.polarity;
      mode_sh     <= pwm_mode_e'(bus.center_mode);
    end
  end

  // Per-channel compare against the shared counter.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    assign raw_c[i] = (cnt < duty_sh[i*CNT_W +: CNT_W]);
  end

  // Output flops; idle (and the start clock) shows the live inactive level.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
    end else if (!bus.en || !run) begin
      pwm_q <= bus.polarity;
    end else begin
      pwm_q <= raw_c ^ pol_sh;
    end
  end

  // One-cycle pulse after each shadow load.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_tick_q <= 1'b0;
    end else begin
      period_tick_q <= load_c;
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.period_tick = period_tick_q;

endmodule
